ispp_program: RTL and testbench
===============================

ISPP_PROGRAM -- requirements
Module: ispp_program

Interface
REQ-001 SHALL have parameter V_ERASE, default 16'h0400: erased-cell threshold voltage, start point of every program.
REQ-002 SHALL have parameter VSTEP, default 16'h0040: nominal ISPP step added per pulse.
REQ-003 SHALL have parameters VERIFY1/VERIFY2/VERIFY3, defaults 16'h2000/16'h4000/16'h6000: verify levels for states 1/2/3.
REQ-004 SHALL have parameter MAX_PULSES, default 8'd255: pulse budget before program failure.
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 inputValid  input  1  inputSymbol is valid this cycle.
REQ-008 inputSymbol  input  2  target cell state, 0..3.
REQ-009 inputReady  output  1  block accepts a symbol this cycle.
REQ-010 outputVoltage  output  32  packed {voltage[15:0], 14'b0, state[1:0]} for the retention stage.
REQ-011 outputValid  output  1  outputVoltage valid, single-cycle pulse.
REQ-012 programFail  output  1  qualifies outputValid: pulse budget exhausted before verify passed.

Function
REQ-013 FSM states SHALL be IDLE, ERASE, PULSE, VERIFY, DONE; inputReady = (state==IDLE).
REQ-014 Accept on inputValid && inputReady: latch symbol, clear pulse counter, go to ERASE; inputValid outside IDLE SHALL be ignored (no queuing).
REQ-015 ERASE: V <= V_ERASE; next state DONE if symbol==0, else PULSE.
REQ-016 PULSE: V <= V + step, saturating at 16'hFFFF; pulse counter +1; next state VERIFY.
REQ-017 VERIFY: if V >= VERIFY[symbol] go DONE with fail=0; else if counter == MAX_PULSES go DONE with fail=1; else go PULSE.
REQ-018 DONE: outputValid=1, outputVoltage={V,14'b0,symbol}, programFail=fail, held exactly one cycle; next state IDLE.
REQ-019 Latency: DONE entered at edge 1+2N after the acceptance edge, N = pulses applied (N=0 for symbol 0); minimum symbol period 3 cycles.
REQ-020 outputVoltage SHALL hold its last value outside DONE; bits [15:2] always zero.
REQ-021 Comparison unsigned 16-bit; saturation takes precedence over wrap-around.

Reset
REQ-022 On reset: state IDLE, V=0, counter=0, outputVoltage=0, outputValid=0, programFail=0, inputReady=1 the following cycle.
REQ-023 Reset mid-program SHALL discard the symbol in flight with no outputValid pulse.

Configuration
REQ-024 With ISPP_JITTER_EN defined, step = VSTEP + lfsr[1:0] (0..3 LSB), LFSR advancing once per PULSE cycle, seeded to 32'h3721AD74 on reset.
REQ-025 Without ISPP_JITTER_EN, step = VSTEP exactly and no LFSR logic is instantiated.

Structure
REQ-026 Shared package ispp_pkg SHALL hold the FSM state encoding, packed-output field offsets, and default voltage constants.
REQ-027 One sub-module ispp_lfsr (32-bit Galois LFSR, sync reset, advance enable) SHALL be instantiated only under ISPP_JITTER_EN.

Verification
REQ-028 Reset, symbol 0 accepted -> one edge later outputValid=1, outputVoltage=32'h04000000, programFail=0.
REQ-029 VSTEP=16'h1000, symbol 1 -> N=2, outputValid at acceptance+5 edges, outputVoltage=32'h24000001.
REQ-030 VSTEP=16'h1000, symbol 3 -> N=6, outputValid at acceptance+13 edges, outputVoltage=32'h64000003.
REQ-031 VSTEP=16'h0040, MAX_PULSES=4, symbol 2 -> outputVoltage=32'h05000002, programFail=1.
REQ-032 inputValid held high during programming, reset asserted mid-PULSE -> no outputValid, inputReady=1 one cycle after reset, next symbol programs correctly.
REQ-033 VSTEP=16'hF000, VERIFY3=16'hFFFF, symbol 3 -> V saturates at 16'hFFFF, outputVoltage=32'hFFFF0003, programFail=0.

Source files
------------

// File: rtl/ispp_pkg.sv
// Shared definitions for the ISPP program stage: FSM encoding, packed-output
// field layout, default voltage constants and the jitter LFSR constants.
package ispp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ERASE  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int OUT_W        = 32;
    localparam int OUT_VOLT_LSB = 16;
    localparam int OUT_VOLT_W   = 16;
    localparam int OUT_SYM_LSB  = 0;
    localparam int OUT_SYM_W    = 2;

    localparam logic [15:0] DEF_V_ERASE    = 16'h0400;
    localparam logic [15:0] DEF_VSTEP      = 16'h0040;
    localparam logic [15:0] DEF_VERIFY1    = 16'h2000;
    localparam logic [15:0] DEF_VERIFY2    = 16'h4000;
    localparam logic [15:0] DEF_VERIFY3    = 16'h6000;
    localparam logic [7:0]  DEF_MAX_PULSES = 8'd255;

    localparam logic [31:0] LFSR_SEED = 32'h3721AD74;
    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    function automatic logic [OUT_W-1:0] pack_output(input logic [15:0] volt,
                                                     input logic [1:0]  sym);
        logic [OUT_W-1:0] word;
        word = '0;
        word[OUT_VOLT_LSB +: OUT_VOLT_W] = volt;
        word[OUT_SYM_LSB +: OUT_SYM_W]   = sym;
        return word;
    endfunction

endpackage

// File: rtl/ispp_lfsr.sv
// 32-bit Galois LFSR with synchronous reset to a fixed seed; advances one
// step per cycle while advance_i is high. Used only for ISPP step jitter.
module ispp_lfsr
    import ispp_pkg::*;
#(
    parameter logic [31:0] SEED = LFSR_SEED,
    parameter logic [31:0] POLY = LFSR_POLY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance_i,
    output logic [31:0] lfsr_o
);

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance_i) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ispp_program.sv
// Incremental-step-pulse programming of one cell: erase, then pulse/verify
// until the target level is reached or the pulse budget runs out.
// Optional step jitter from an LFSR is enabled by defining ISPP_JITTER_EN.
module ispp_program
    import ispp_pkg::*;
#(
    parameter logic [15:0] V_ERASE    = DEF_V_ERASE,
    parameter logic [15:0] VSTEP      = DEF_VSTEP,
    parameter logic [15:0] VERIFY1    = DEF_VERIFY1,
    parameter logic [15:0] VERIFY2    = DEF_VERIFY2,
    parameter logic [15:0] VERIFY3    = DEF_VERIFY3,
    parameter logic [7:0]  MAX_PULSES = DEF_MAX_PULSES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inputValid,
    input  logic [1:0]       inputSymbol,
    output logic             inputReady,
    output logic [OUT_W-1:0] outputVoltage,
    output logic             outputValid,
    output logic             programFail
);

    state_e           state_q, state_d;
    logic [15:0]      volt_q, volt_d;
    logic [7:0]       pulses_q, pulses_d;
    logic [1:0]       sym_q, sym_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             fail_q, fail_d;
    logic [15:0]      step;

    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Symbol 0 never reaches VERIFY; its entry is irrelevant.
    function automatic logic [15:0] verify_level(input logic [1:0] sym);
        case (sym)
            2'd1:    return VERIFY1;
            2'd2:    return VERIFY2;
            2'd3:    return VERIFY3;
            default: return 16'h0000;
        endcase
    endfunction

`ifdef ISPP_JITTER_EN
    logic [31:0] lfsr;

    ispp_lfsr u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .advance_i (state_q == ST_PULSE),
        .lfsr_o    (lfsr)
    );

    assign step = VSTEP + {14'b0, lfsr[1:0]};
`else
    assign step = VSTEP;
`endif

    always_comb begin
        state_d  = state_q;
        volt_d   = volt_q;
        pulses_d = pulses_q;
        sym_d    = sym_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        fail_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inputValid) begin
                    sym_d    = inputSymbol;
                    pulses_d = '0;
                    state_d  = ST_ERASE;
                end
            end
            ST_ERASE: begin
                volt_d = V_ERASE;
                if (sym_q == 2'd0) begin
                    state_d = ST_DONE;
                    out_d   = pack_output(V_ERASE, sym_q);
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                volt_d   = sat_add16(volt_q, step);
                pulses_d = pulses_q + 8'd1;
                state_d  = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (volt_q >= verify_level(sym_q)) begin
                    state_d = ST_DONE;
                    out_d   = pack_output(volt_q, sym_q);
                    valid_d = 1'b1;
                end else if (pulses_q == MAX_PULSES) begin
                    state_d = ST_DONE;
                    out_d   = pack_output(volt_q, sym_q);
                    valid_d = 1'b1;
                    fail_d  = 1'b1;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            volt_q   <= '0;
            pulses_q <= '0;
            sym_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            volt_q   <= volt_d;
            pulses_q <= pulses_d;
            sym_q    <= sym_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            fail_q   <= fail_d;
        end
    end

    // Output registers load on the edge that enters DONE, so they line up
    // with the single DONE cycle; the voltage word then holds until the next.
    assign inputReady    = (state_q == ST_IDLE);
    assign outputVoltage = out_q;
    assign outputValid   = valid_q;
    assign programFail   = fail_q;

endmodule

// File: tb/tb_ispp_program.sv
// Bench for ispp_program: four parameterisations driven with directed and
// random symbols, checked against an arithmetic model of the ISPP rules.
module tb_ispp_program;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv   [NI];
    logic [1:0]  isym [NI];
    logic        rdy  [NI];
    logic [31:0] ov   [NI];
    logic        vld  [NI];
    logic        pf   [NI];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ispp_program u_dut0 (
        .clk(clk), .reset(reset), .inputValid(iv[0]), .inputSymbol(isym[0]),
        .inputReady(rdy[0]), .outputVoltage(ov[0]), .outputValid(vld[0]),
        .programFail(pf[0])
    );

    ispp_program #(.VSTEP(16'h1000)) u_dut1 (
        .clk(clk), .reset(reset), .inputValid(iv[1]), .inputSymbol(isym[1]),
        .inputReady(rdy[1]), .outputVoltage(ov[1]), .outputValid(vld[1]),
        .programFail(pf[1])
    );

    ispp_program #(.VSTEP(16'h0040), .MAX_PULSES(8'd4)) u_dut2 (
        .clk(clk), .reset(reset), .inputValid(iv[2]), .inputSymbol(isym[2]),
        .inputReady(rdy[2]), .outputVoltage(ov[2]), .outputValid(vld[2]),
        .programFail(pf[2])
    );

    ispp_program #(.VSTEP(16'hF000), .VERIFY3(16'hFFFF)) u_dut3 (
        .clk(clk), .reset(reset), .inputValid(iv[3]), .inputSymbol(isym[3]),
        .inputReady(rdy[3]), .outputVoltage(ov[3]), .outputValid(vld[3]),
        .programFail(pf[3])
    );

    function automatic int cfg_step(input int idx);
        case (idx)
            1:       return 'h1000;
            3:       return 'hF000;
            default: return 'h0040;
        endcase
    endfunction

    function automatic int cfg_verify(input int idx, input logic [1:0] sym);
        case (sym)
            2'd1:    return 'h2000;
            2'd2:    return 'h4000;
            2'd3:    return (idx == 3) ? 'hFFFF : 'h6000;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_max(input int idx);
        return (idx == 2) ? 4 : 255;
    endfunction

    // Expected final voltage word, fail flag and edges from acceptance to DONE.
    task automatic model(input int idx, input logic [1:0] sym,
                         output logic [31:0] exp_out, output logic exp_fail,
                         output int exp_edges);
        int v;
        int n;
        v        = 'h0400;
        n        = 0;
        exp_fail = 1'b0;
        if (sym != 2'd0) begin
            while (1) begin
                v = v + cfg_step(idx);
                if (v > 'hFFFF) v = 'hFFFF;
                n++;
                if (v >= cfg_verify(idx, sym)) break;
                if (n == cfg_max(idx)) begin
                    exp_fail = 1'b1;
                    break;
                end
            end
        end
        exp_out   = {v[15:0], 14'b0, sym};
        exp_edges = 1 + 2 * n;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after the acceptance edge; returns at the
    // negedge one cycle after the DONE cycle.
    task automatic wait_result(input int idx, input logic [1:0] sym,
                               input string tag, input bit noise);
        logic [31:0] e_out;
        logic        e_fail;
        int          e_edges;
        int          edges;
        bit          seen;
        model(idx, sym, e_out, e_fail, e_edges);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 1000) begin
            if (noise) begin
                iv[idx]   = 1'($urandom_range(0, 1));
                isym[idx] = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (vld[idx] === 1'b1) seen = 1'b1;
        end
        iv[idx] = 1'b0;
        check({tag, " seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(edges), 32'(e_edges));
        check({tag, " voltage"}, ov[idx], e_out);
        check({tag, " fail"}, 32'(pf[idx]), 32'(e_fail));
        @(negedge clk);
        check({tag, " valid_width"}, 32'(vld[idx]), 32'd0);
        check({tag, " voltage_hold"}, ov[idx], e_out);
        check({tag, " ready_after"}, 32'(rdy[idx]), 32'd1);
    endtask

    task automatic run_txn(input int idx, input logic [1:0] sym,
                           input string tag, input bit noise);
        check({tag, " ready_before"}, 32'(rdy[idx]), 32'd1);
        iv[idx]   = 1'b1;
        isym[idx] = sym;
        @(posedge clk);
        @(negedge clk);
        iv[idx]   = 1'b0;
        isym[idx] = 2'($urandom_range(0, 3));
        check({tag, " ready_busy"}, 32'(rdy[idx]), 32'd0);
        wait_result(idx, sym, tag, noise);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            iv[i]   = 1'b0;
            isym[i] = 2'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check("reset ready", 32'(rdy[i]), 32'd1);
            check("reset voltage", ov[i], 32'h0);
            check("reset valid", 32'(vld[i]), 32'd0);
            check("reset fail", 32'(pf[i]), 32'd0);
        end

        run_txn(0, 2'd0, "sym0_default", 1'b0);
        run_txn(1, 2'd1, "sym1_step1000", 1'b0);
        run_txn(1, 2'd3, "sym3_step1000", 1'b0);
        run_txn(2, 2'd2, "sym2_budget4", 1'b0);
        run_txn(3, 2'd3, "sym3_saturate", 1'b0);
        run_txn(0, 2'd1, "sym1_default", 1'b0);
        run_txn(0, 2'd3, "sym3_default_fail", 1'b0);

        for (int k = 0; k < 24; k++) begin
            run_txn(k % NI, 2'($urandom_range(0, 3)), "random", 1'b1);
        end

        // Reset during programming with inputValid held high throughout.
        iv[1]   = 1'b1;
        isym[1] = 2'd3;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("midreset no_valid", 32'(vld[1]), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midreset ready", 32'(rdy[1]), 32'd1);
        check("midreset valid", 32'(vld[1]), 32'd0);
        check("midreset voltage", ov[1], 32'h0);
        check("midreset fail", 32'(pf[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        iv[1] = 1'b0;
        check("midreset accepted", 32'(rdy[1]), 32'd0);
        wait_result(1, 2'd3, "after_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
